// File: rtl/i2s_rx_fifo.sv
// I2S receiver: oversamples BCLK/LRCLK/DATA on audio_clk_i, assembles 16-bit
// left/right words into {R, L} pairs and buffers them for the S/PDIF core.
module i2s_rx_fifo #(
  parameter int FIFO_ADDR_W = 2
) (
  input  logic                   audio_clk_i,
  input  logic                   rst_i,
  input  logic                   i2s_bclk_i,
  input  logic                   i2s_lrclk_i,
  input  logic                   i2s_data_i,
  output logic [31:0]            sample_o,
  input  logic                   sample_req_i,
  output logic [FIFO_ADDR_W:0]   fifo_level_o,
  output logic                   overflow_o,
  output logic                   underrun_o,
  input  logic                   clear_status_i
);

  localparam int DEPTH       = 1 << FIFO_ADDR_W;
  localparam int SAMPLE_BITS = 16;

  logic bclk_p0, bclk_p1, bclk_p2;
  logic lr_p0, lr_p1;
  logic data_p0, data_p1;
  logic bclk_rise;

  logic                   lr_prev, aligned, chan, left_ok, push_pend;
  logic [4:0]             bit_cnt;
  logic                   lr_change, cap_bit, word_done;
  logic [SAMPLE_BITS-1:0] shift_q, shift_next, left_q, right_q;

  logic [31:0]            mem [DEPTH];
  logic [FIFO_ADDR_W:0]   wr_ptr, rd_ptr, level;
  logic                   empty, full, do_pop, do_push, ov_set, un_set;

  // Stage p0..p2: two-flop synchronisers, third BCLK flop for edge detect
  always_ff @(posedge audio_clk_i or posedge rst_i) begin
    if (rst_i) begin
      bclk_p0 <= 1'b0; bclk_p1 <= 1'b0; bclk_p2 <= 1'b0;
      lr_p0   <= 1'b0; lr_p1   <= 1'b0;
      data_p0 <= 1'b0; data_p1 <= 1'b0;
    end else begin
      bclk_p0 <= i2s_bclk_i;  bclk_p1 <= bclk_p0; bclk_p2 <= bclk_p1;
      lr_p0   <= i2s_lrclk_i; lr_p1   <= lr_p0;
      data_p0 <= i2s_data_i;  data_p1 <= data_p0;
    end
  end

  assign bclk_rise  = bclk_p1 & ~bclk_p2;
  assign lr_change  = bclk_rise & (lr_p1 != lr_prev);
  assign cap_bit    = bclk_rise & ~lr_change & aligned & (bit_cnt < 5'(SAMPLE_BITS));
  assign word_done  = cap_bit & (bit_cnt == 5'(SAMPLE_BITS - 1));
  assign shift_next = {shift_q[SAMPLE_BITS-2:0], data_p1};

  // Stage: word framing and pair assembly, one step per BCLK rising strobe
  always_ff @(posedge audio_clk_i or posedge rst_i) begin
    if (rst_i) begin
      lr_prev   <= 1'b0;
      aligned   <= 1'b0;
      chan      <= 1'b0;
      left_ok   <= 1'b0;
      push_pend <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      push_pend <= 1'b0;
      if (bclk_rise) lr_prev <= lr_p1;
      if (lr_change) begin
        bit_cnt <= '0;
        chan    <= lr_p1;
        aligned <= 1'b1;
        // New left slot, or an interrupted short left word, invalidates the pair
        if (!lr_p1 || (!chan && bit_cnt < 5'(SAMPLE_BITS))) left_ok <= 1'b0;
      end else if (cap_bit) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (word_done) begin
          if (!chan) begin
            left_ok <= 1'b1;
          end else if (left_ok) begin
            push_pend <= 1'b1;
            left_ok   <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge audio_clk_i) begin
    if (cap_bit) shift_q <= shift_next;
    if (word_done) begin
      if (chan) right_q <= shift_next;
      else      left_q  <= shift_next;
    end
  end

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (FIFO_ADDR_W+1)'(DEPTH));
  assign do_pop  = sample_req_i & ~empty;
  assign do_push = push_pend & (~full | do_pop);
  assign ov_set  = push_pend & full & ~do_pop;
  assign un_set  = sample_req_i & empty;

  // Stage: FIFO write/read, one cycle after the final right-bit strobe
  always_ff @(posedge audio_clk_i) begin
    if (do_push) mem[wr_ptr[FIFO_ADDR_W-1:0]] <= {right_q, left_q};
  end

  always_ff @(posedge audio_clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      sample_o   <= '0;
      overflow_o <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        sample_o <= mem[rd_ptr[FIFO_ADDR_W-1:0]];
      end
      if (ov_set)              overflow_o <= 1'b1;
      else if (clear_status_i) overflow_o <= 1'b0;
      if (un_set)              underrun_o <= 1'b1;
      else if (clear_status_i) underrun_o <= 1'b0;
    end
  end

  assign fifo_level_o = level;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Directed bench for i2s_rx_fifo: drives 16x-oversampled I2S frames and checks
// every cycle against a slot-level model with a queue-based FIFO.
module tb_i2s_rx_fifo;
  localparam int A   = 2;
  localparam int CAP = 1 << A;

  logic        clk = 1'b0, rst = 1'b1;
  logic        bclk = 1'b0, lrclk = 1'b0, sdata = 1'b0;
  logic        req_man = 1'b0, req_sched = 1'b0, clr = 1'b0;
  logic        sample_req;
  logic [31:0] sample;
  logic [A:0]  level;
  logic        ov, un;

  assign sample_req = req_man | req_sched;

  i2s_rx_fifo #(.FIFO_ADDR_W(A)) dut (
    .audio_clk_i   (clk),
    .rst_i         (rst),
    .i2s_bclk_i    (bclk),
    .i2s_lrclk_i   (lrclk),
    .i2s_data_i    (sdata),
    .sample_o      (sample),
    .sample_req_i  (sample_req),
    .fifo_level_o  (level),
    .overflow_o    (ov),
    .underrun_o    (un),
    .clear_status_i(clr)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  // Model state: stored pairs, held output, sticky flags, scheduled pushes
  logic [31:0] m_q[$];
  logic [31:0] m_sample = '0;
  logic        m_ov = 1'b0, m_un = 1'b0;
  int          push_t[$];
  logic [31:0] push_d[$];
  int          sched_req_time = -1;

  always @(posedge clk) begin
    logic        pn, os, us;
    logic [31:0] pd;
    cyc++;
    if (rst) begin
      m_q.delete(); push_t.delete(); push_d.delete();
      m_sample = '0; m_ov = 1'b0; m_un = 1'b0;
    end else begin
      pn = 1'b0; pd = '0; os = 1'b0; us = 1'b0;
      if (push_t.size() > 0 && push_t[0] == cyc) begin
        pn = 1'b1;
        pd = push_d.pop_front();
        void'(push_t.pop_front());
      end
      if (sample_req) begin
        if (m_q.size() == 0) us = 1'b1;
        else m_sample = m_q.pop_front();
      end
      if (pn) begin
        if (m_q.size() < CAP) m_q.push_back(pd);
        else os = 1'b1;
      end
      m_ov = os | (m_ov & ~clr);
      m_un = us | (m_un & ~clr);
    end
    #1;
    chk("sample_o", sample, m_sample);
    chk("fifo_level_o", 32'(level), 32'(m_q.size()));
    chk("overflow_o", 32'(ov), 32'(m_ov));
    chk("underrun_o", 32'(un), 32'(m_un));
  end

  always @(negedge clk) req_sched = (cyc + 1 == sched_req_time);

  // Slot-level view of the framer: which completed slots form a pair
  logic        lr_prev_m = 1'b0, aligned_m = 1'b0, left_ok_m = 1'b0, pop_with_push = 1'b0;
  logic [15:0] left_w = '0;

  task automatic send_slot(input logic ch, input logic [15:0] w, input int nbits, input int nbclk);
    for (int i = 0; i < nbclk; i++) begin
      @(negedge clk);
      bclk = 1'b0; lrclk = ch;
      if (i >= 1 && i <= nbits && i <= 16) sdata = w[16-i];
      else sdata = 1'($urandom_range(1));
      repeat (7) @(negedge clk);
      @(negedge clk);
      bclk = 1'b1;
      if (i == 0) begin
        if (ch != lr_prev_m) begin
          aligned_m = 1'b1;
          if (!ch) left_ok_m = 1'b0;
        end
        lr_prev_m = ch;
      end
      if (i == 16 && nbits >= 16 && aligned_m) begin
        if (!ch) begin
          left_ok_m = 1'b1;
          left_w    = w;
        end else if (left_ok_m) begin
          push_t.push_back(cyc + 4);
          push_d.push_back({w, left_w});
          if (pop_with_push) sched_req_time = cyc + 4;
          left_ok_m = 1'b0;
        end
      end
      repeat (7) @(negedge clk);
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 16, 32);
    send_slot(1'b1, r, 16, 32);
  endtask

  task automatic pop();
    @(negedge clk); req_man = 1'b1;
    @(negedge clk); req_man = 1'b0;
  endtask

  task automatic clear_status();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_sample", sample, 32'h0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_flags", {30'd0, ov, un}, 32'd0);
    rst = 1'b0;

    // Basic capture: a leading right slot has no left partner and is dropped
    send_slot(1'b1, 16'h0000, 16, 32);
    frame(16'h1234, 16'hABCD);
    chk("basic_level1", 32'(level), 32'd1);
    pop();
    chk("basic_sample", sample, 32'hABCD1234);
    chk("basic_level0", 32'(level), 32'd0);

    // Overflow: five frames into four entries
    for (int k = 1; k <= 5; k++) frame(16'h0010 + 16'(k), 16'h0A00 + 16'(k));
    chk("ovf_level", 32'(level), 32'd4);
    chk("ovf_flag", 32'(ov), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      pop();
      chk("ovf_order", sample, {16'h0A00 + 16'(k), 16'h0010 + 16'(k)});
    end
    chk("ovf_drained", 32'(level), 32'd0);

    // Underrun: pop past empty holds the last value
    frame(16'h0002, 16'h0001);
    pop();
    chk("unr_first", sample, 32'h00010002);
    pop();
    chk("unr_hold", sample, 32'h00010002);
    chk("unr_flag", 32'(un), 32'd1);
    clear_status();
    chk("unr_clear", {30'd0, ov, un}, 32'd0);

    // Push and pop together while full, across the pointer wrap
    for (int k = 1; k <= 4; k++) frame(16'h0200 + 16'(k), 16'h0300 + 16'(k));
    chk("full_level", 32'(level), 32'd4);
    pop_with_push = 1'b1;
    frame(16'h0205, 16'h0305);
    pop_with_push = 1'b0;
    chk("full_pp_level", 32'(level), 32'd4);
    chk("full_pp_ovf", 32'(ov), 32'd0);
    for (int k = 2; k <= 5; k++) begin
      pop();
      chk("full_pp_order", sample, {16'h0300 + 16'(k), 16'h0200 + 16'(k)});
    end

    // Reset mid-word with the FIFO partly full
    frame(16'h0C01, 16'h0D01);
    frame(16'h0C02, 16'h0D02);
    chk("pre_rst_level", 32'(level), 32'd2);
    send_slot(1'b0, 16'hBEEF, 8, 9);
    @(negedge clk); bclk = 1'b0; rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_rst_sample", sample, 32'h0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_flags", {30'd0, ov, un}, 32'd0);
    rst = 1'b0;
    lr_prev_m = 1'b0; aligned_m = 1'b0; left_ok_m = 1'b0;

    // Alignment errors: partial right start, short left slot
    send_slot(1'b1, 16'hFFFF, 12, 12);
    frame(16'h5555, 16'h6666);
    send_slot(1'b0, 16'h9999, 10, 11);
    send_slot(1'b1, 16'h7777, 16, 32);
    frame(16'h1357, 16'h2468);
    chk("align_level", 32'(level), 32'd2);
    pop();
    chk("align_first", sample, 32'h66665555);
    pop();
    chk("align_second", sample, 32'h24681357);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
